// File: rtl/sent_tx_crc_sched_if.sv
// Request/grant/result bundle between the SENT transmitter front end and the
// shared CRC scheduler. The master is the requesting side; the slave is the
// scheduler.
interface sent_tx_crc_sched_if;
    logic        fast_req;
    logic [1:0]  fast_len;
    logic [23:0] fast_data;
    logic        ser_req;
    logic        ser_enh;
    logic [23:0] ser_data;
    logic        fast_ack;
    logic        ser_ack;
    logic        fast_done;
    logic        ser_done;
    logic [3:0]  fast_crc;
    logic [5:0]  ser_crc;
    logic        busy;

    modport master (
        output fast_req, fast_len, fast_data,
        output ser_req, ser_enh, ser_data,
        input  fast_ack, ser_ack, fast_done, ser_done,
        input  fast_crc, ser_crc, busy
    );

    modport slave (
        input  fast_req, fast_len, fast_data,
        input  ser_req, ser_enh, ser_data,
        output fast_ack, ser_ack, fast_done, ser_done,
        output fast_crc, ser_crc, busy
    );
endinterface

// File: rtl/sent_tx_crc_sched.sv
// Shared bit-serial CRC engine for a SENT transmitter. Fast-channel frames
// (CRC4 over 3, 4 or 6 nibbles) and serial messages (CRC4 short, CRC6
// enhanced) compete for one engine; contention is resolved round-robin.
// Each job: grant in IDLE, one bit per SHIFT cycle (data MSB first, then
// W zero bits of augmentation), result published in DONE.
module sent_tx_crc_sched (
    input logic               clk,
    input logic               reset,
    sent_tx_crc_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] SEED4 = 6'b000101;
    localparam logic [5:0] SEED6 = 6'b010101;
    localparam logic [3:0] POLY4 = 4'b1101;
    localparam logic [5:0] POLY6 = 6'b011001;

    state_t      state;
    logic [4:0]  step_cnt;
    logic [5:0]  crc_reg;
    logic [29:0] bit_stream;
    logic        owner_ser;
    logic        mode_crc6;
    logic        last_grant_ser;
    logic        fast_done_q;
    logic        ser_done_q;
    logic        busy_q;
    logic [3:0]  fast_crc_q;
    logic [5:0]  ser_crc_q;

    logic        grant_fast;
    logic        grant_ser;
    logic [5:0]  crc_next;
    logic [4:0]  fast_steps;
    logic [29:0] fast_stream;

    // Grant decision, only in IDLE and never while reset is asserted; the ack is
    // taken straight from this so the requester sees it in the grant cycle.
    always_comb begin
        grant_fast = 1'b0;
        grant_ser  = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.fast_req && (!bus.ser_req || last_grant_ser)) begin
                grant_fast = 1'b1;
            end else if (bus.ser_req) begin
                grant_ser = 1'b1;
            end
        end
    end

    // Fast-frame length decode: step count and left-aligned bit stream (reserved length acts as 6 nibbles).
    always_comb begin
        case (bus.fast_len)
            2'b00: begin
                fast_steps  = 5'd16;
                fast_stream = {bus.fast_data[11:0], 18'd0};
            end
            2'b01: begin
                fast_steps  = 5'd20;
                fast_stream = {bus.fast_data[15:0], 14'd0};
            end
            default: begin
                fast_steps  = 5'd28;
                fast_stream = {bus.fast_data[23:0], 6'd0};
            end
        endcase
    end

    // One CRC engine step: shift in the next stream bit, fold the polynomial back in when the old MSB was set.
    always_comb begin
        crc_next = 6'd0;
        if (mode_crc6) begin
            crc_next = {crc_reg[4:0], bit_stream[29]};
            if (crc_reg[5]) begin
                crc_next = crc_next ^ POLY6;
            end
        end else begin
            crc_next[3:0] = {crc_reg[2:0], bit_stream[29]};
            if (crc_reg[3]) begin
                crc_next[3:0] = crc_next[3:0] ^ POLY4;
            end
        end
    end

    // Scheduler FSM with registered results; the final SHIFT step writes the owner's result so it is valid during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            step_cnt       <= 5'd0;
            crc_reg        <= 6'd0;
            bit_stream     <= 30'd0;
            owner_ser      <= 1'b0;
            mode_crc6      <= 1'b0;
            last_grant_ser <= 1'b1;
            fast_done_q    <= 1'b0;
            ser_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            fast_crc_q     <= 4'd0;
            ser_crc_q      <= 6'd0;
        end else begin
            fast_done_q <= 1'b0;
            ser_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fast) begin
                        owner_ser      <= 1'b0;
                        mode_crc6      <= 1'b0;
                        last_grant_ser <= 1'b0;
                        crc_reg        <= SEED4;
                        step_cnt       <= fast_steps;
                        bit_stream     <= fast_stream;
                        busy_q         <= 1'b1;
                        state          <= SHIFT;
                    end else if (grant_ser) begin
                        owner_ser      <= 1'b1;
                        last_grant_ser <= 1'b1;
                        busy_q         <= 1'b1;
                        state          <= SHIFT;
                        if (bus.ser_enh) begin
                            mode_crc6  <= 1'b1;
                            crc_reg    <= SEED6;
                            step_cnt   <= 5'd30;
                            bit_stream <= {bus.ser_data, 6'd0};
                        end else begin
                            mode_crc6  <= 1'b0;
                            crc_reg    <= SEED4;
                            step_cnt   <= 5'd12;
                            bit_stream <= {bus.ser_data[7:0], 22'd0};
                        end
                    end
                end
                SHIFT: begin
                    crc_reg    <= crc_next;
                    bit_stream <= {bit_stream[28:0], 1'b0};
                    step_cnt   <= step_cnt - 5'd1;
                    if (step_cnt == 5'd1) begin
                        state <= DONE;
                        if (owner_ser) begin
                            ser_done_q <= 1'b1;
                            ser_crc_q  <= mode_crc6 ? crc_next : {2'b00, crc_next[3:0]};
                        end else begin
                            fast_done_q <= 1'b1;
                            fast_crc_q  <= crc_next[3:0];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fast_ack  = grant_fast;
    assign bus.ser_ack   = grant_ser;
    assign bus.fast_done = fast_done_q;
    assign bus.ser_done  = ser_done_q;
    assign bus.fast_crc  = fast_crc_q;
    assign bus.ser_crc   = ser_crc_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sent_tx_crc_sched.sv
// Directed and randomised bench for the shared SENT CRC scheduler, with a
// polynomial long-division reference for the expected CRC values.
module tb_sent_tx_crc_sched;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sent_tx_crc_sched_if bus();

    sent_tx_crc_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC: long division of {seed, data, W zeros} by the full generator polynomial.
    function automatic logic [5:0] refCrc(input bit crc6, input int nbits, input logic [23:0] data);
        logic [63:0] m;
        logic [63:0] d;
        logic [63:0] poly;
        logic [63:0] seed;
        int w;
        w    = crc6 ? 6 : 4;
        seed = crc6 ? 64'h15 : 64'h5;
        poly = crc6 ? 64'h59 : 64'h1D;
        d    = {40'd0, data};
        if (nbits < 24) d = d & ((64'd1 << nbits) - 64'd1);
        m = (seed << (nbits + w)) | (d << w);
        for (int i = nbits + 2 * w - 1; i >= w; i--) begin
            if (m[i]) m = m ^ (poly << (i - w));
        end
        return crc6 ? m[5:0] : {2'b00, m[3:0]};
    endfunction

    // Number of payload bits a job covers.
    function automatic int jobBits(input bit is_ser, input logic [1:0] len, input bit enh);
        if (is_ser) return enh ? 24 : 8;
        if (len == 2'b00) return 12;
        if (len == 2'b01) return 16;
        return 24;
    endfunction

    // One complete job: request, check same-cycle ack, drop req and scramble inputs, check done latency and CRC.
    task automatic applyStimulus(input bit is_ser, input logic [1:0] len, input bit enh,
                                 input logic [23:0] data, input int n,
                                 input logic [5:0] exp_crc, input string tag);
        int lat;
        @(posedge clk); #1;
        if (is_ser) begin
            bus.ser_req  = 1'b1;
            bus.ser_enh  = enh;
            bus.ser_data = data;
        end else begin
            bus.fast_req  = 1'b1;
            bus.fast_len  = len;
            bus.fast_data = data;
        end
        @(negedge clk);
        checkOutput({tag, ".ack"}, is_ser ? bus.ser_ack : bus.fast_ack, 1);
        @(posedge clk); #1;
        bus.fast_req  = 1'b0;
        bus.ser_req   = 1'b0;
        bus.fast_data = 24'($urandom);
        bus.ser_data  = 24'($urandom);
        bus.fast_len  = 2'($urandom);
        bus.ser_enh   = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput({tag, ".busy"}, bus.busy, 1);
            if (is_ser ? bus.ser_done : bus.fast_done) lat = k;
            if (lat != 0) break;
        end
        checkOutput({tag, ".lat"}, lat, n + 1);
        checkOutput({tag, ".crc"}, is_ser ? bus.ser_crc : {2'b00, bus.fast_crc}, exp_crc);
    endtask

    initial begin
        int          lat;
        bit          saw_ser;
        bit          is_ser;
        bit          enh;
        logic [1:0]  len;
        logic [23:0] data;
        int          nb;
        logic [4:0]  exp_vec;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.fast_req  = 1'b0;
        bus.fast_len  = 2'b00;
        bus.fast_data = 24'd0;
        bus.ser_req   = 1'b0;
        bus.ser_enh   = 1'b0;
        bus.ser_data  = 24'd0;

        // Reset state, and reset beats a pending request.
        repeat (2) @(posedge clk);
        #1 bus.fast_req = 1'b1;
        @(negedge clk);
        checkOutput("rst.busy", bus.busy, 0);
        checkOutput("rst.fast_crc", bus.fast_crc, 0);
        checkOutput("rst.ser_crc", bus.ser_crc, 0);
        checkOutput("rst.fast_ack", bus.fast_ack, 0);
        checkOutput("rst.done", {bus.fast_done, bus.ser_done}, 0);
        @(posedge clk); #1;
        bus.fast_req = 1'b0;
        reset        = 1'b0;
        @(negedge clk);
        checkOutput("idle.busy", bus.busy, 0);

        // Directed all-zero vectors with hand-computed results.
        applyStimulus(1'b0, 2'b00, 1'b0, 24'h000000, 16, 6'h09, "fast3_zero");
        applyStimulus(1'b0, 2'b01, 1'b0, 24'h000000, 20, 6'h0C, "fast4_zero");
        applyStimulus(1'b0, 2'b10, 1'b0, 24'h000000, 28, 6'h05, "fast6_zero");
        applyStimulus(1'b0, 2'b11, 1'b0, 24'h000000, 28, 6'h05, "fast_rsvd_zero");
        applyStimulus(1'b1, 2'b00, 1'b0, 24'hFFFF00, 12, 6'h06, "short_zero");
        applyStimulus(1'b1, 2'b00, 1'b1, 24'h000000, 30, 6'h26, "enh_zero");

        // Unused upper fast bits are masked; serial result is left alone by a fast job.
        applyStimulus(1'b0, 2'b00, 1'b0, 24'hFFF123, 16, refCrc(1'b0, 12, 24'h000123), "fast3_mask");
        checkOutput("ser_hold", bus.ser_crc, 6'h26);

        // Random modes, data and idle gaps against the long-division reference.
        for (int j = 0; j < 20; j++) begin
            is_ser = 1'($urandom);
            len    = 2'($urandom);
            enh    = 1'($urandom);
            data   = 24'($urandom);
            nb     = jobBits(is_ser, len, enh);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus(is_ser, len, enh, data,
                          nb + ((is_ser && enh) ? 6 : 4),
                          refCrc(is_ser && enh, nb, data),
                          $sformatf("rnd%0d", j));
        end

        // Reset in the middle of an enhanced job: no done, outputs cleared, pending fast request granted right after.
        @(posedge clk); #1;
        bus.ser_req  = 1'b1;
        bus.ser_enh  = 1'b1;
        bus.ser_data = 24'hABCDEF;
        @(negedge clk);
        checkOutput("mid.ser_ack", bus.ser_ack, 1);
        @(posedge clk); #1;
        bus.ser_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.fast_req  = 1'b1;
        bus.fast_len  = 2'b01;
        bus.fast_data = 24'h001234;
        @(negedge clk);
        checkOutput("mid.shift_noack", bus.fast_ack, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid.rst_noack", bus.fast_ack, 0);
        checkOutput("mid.rst_nodone", bus.ser_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid.busy", bus.busy, 0);
        checkOutput("mid.ser_crc", bus.ser_crc, 0);
        checkOutput("mid.fast_crc", bus.fast_crc, 0);
        checkOutput("mid.ser_done", bus.ser_done, 0);
        checkOutput("mid.fast_ack", bus.fast_ack, 1);
        @(posedge clk); #1;
        bus.fast_req = 1'b0;
        lat     = 0;
        saw_ser = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.ser_done) saw_ser = 1'b1;
            if (bus.fast_done) lat = k;
            if (lat != 0) break;
        end
        checkOutput("mid.lat", lat, 21);
        checkOutput("mid.crc", {2'b00, bus.fast_crc}, refCrc(1'b0, 16, 24'h001234));
        checkOutput("mid.no_ser_done", saw_ser, 0);

        // Contention straight after reset: fast, serial, fast with requests held throughout.
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.fast_req  = 1'b1;
        bus.fast_len  = 2'b00;
        bus.fast_data = 24'h000ABC;
        bus.ser_req   = 1'b1;
        bus.ser_enh   = 1'b0;
        bus.ser_data  = 24'h00005A;
        for (int c = 0; c <= 33; c++) begin
            @(negedge clk);
            exp_vec = {(c == 0 || c == 32), (c == 18), (c == 17), (c == 31),
                       !(c == 0 || c == 18 || c == 32)};
            checkOutput($sformatf("rr.c%0d", c),
                        {bus.fast_ack, bus.ser_ack, bus.fast_done, bus.ser_done, bus.busy},
                        exp_vec);
            if (c == 17) checkOutput("rr.fast_crc", {2'b00, bus.fast_crc}, refCrc(1'b0, 12, 24'h000ABC));
            if (c == 31) checkOutput("rr.ser_crc", bus.ser_crc, refCrc(1'b0, 8, 24'h00005A));
            @(posedge clk); #1;
            if (c == 32) begin
                bus.fast_req = 1'b0;
                bus.ser_req  = 1'b0;
            end
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("rr.drain_busy", bus.busy, 0);
        checkOutput("rr.fast_crc2", {2'b00, bus.fast_crc}, refCrc(1'b0, 12, 24'h000ABC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
